duty_meter: RTL and testbench
=============================

DUTY_METER -- requirements
Module: duty_meter

Interface
REQ-001 Parameter SETTLE, default 2: clocks waited after the gate closes before sampling the counts, covering the upstream latch.
REQ-002 Parameter SCALE, default 1000: full-scale duty value (per-mille).
REQ-003 clk  in  1  single system clock; all logic is on its rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 fgate  in  1  measurement gate, synchronous to clk; a falling edge ends a measurement window.
REQ-006 cnt_high  in  32  high-time clock count from the upstream period counter.
REQ-007 cnt_low  in  32  low-time clock count from the upstream period counter.
REQ-008 duty  out  16  duty cycle = floor(cnt_high*SCALE/(cnt_high+cnt_low)), registered.
REQ-009 valid  out  1  one-cycle pulse when duty/err update.
REQ-010 busy  out  1  high from gate-close detection until valid.
REQ-011 err  out  1  divide-by-zero flag for the last result.
REQ-012 ovr  out  1  one-cycle pulse when a gate close is dropped because busy is high.

Function
REQ-013 The block SHALL register fgate once and detect a close at edge E, where E is the first edge with the registered value 1 and fgate 0.
REQ-014 FSM states: IDLE, WAIT, LOAD, DIV, DONE.
- IDLE: on close -> WAIT, settle counter = 0.
- WAIT: stay SETTLE cycles -> LOAD.
- LOAD: capture both counts -> DIV.
- DIV: 42 iterations -> DONE.
- DONE: 1 cycle -> IDLE.
REQ-015 In LOAD the block SHALL form dividend = cnt_high*SCALE (42 bits, zero-extended) and divisor = cnt_high+cnt_low (33 bits, carry kept; no 32-bit wrap).
REQ-016 If divisor == 0 in LOAD, the block SHALL skip DIV and go straight to DONE, with duty = 0 and err = 1.
REQ-017 DIV SHALL be restoring division, one quotient bit per cycle MSB-first, with truncation (no rounding); quotient bits above 15 are always 0 because the quotient is <= SCALE.
REQ-018 duty and err SHALL update and valid SHALL pulse at edge E+SETTLE+44 for a nonzero divisor, and at edge E+SETTLE+2 for a zero divisor.
REQ-019 duty and err SHALL hold their values between valid pulses.
REQ-020 busy SHALL be 1 in WAIT, LOAD, DIV and DONE, and 0 in IDLE.
REQ-021 A gate close detected outside IDLE SHALL be ignored, SHALL pulse ovr for one cycle, and SHALL NOT disturb the current computation.
REQ-022 A gate close in the same cycle as DONE SHALL be treated as overrun, since the FSM is not in IDLE.
REQ-023 cnt_high/cnt_low changes outside LOAD SHALL NOT affect the result.

Reset
REQ-024 While rst is 1: state = IDLE; duty = 0, valid = 0, busy = 0, err = 0, ovr = 0; fgate register = 0; all datapath registers = 0.
REQ-025 Reset asserted mid-computation SHALL abort it with no valid pulse.
REQ-026 After rst is released, the first close SHALL require a 1-to-0 transition of fgate; a gate that is already low SHALL NOT trigger.

Structure
REQ-027 Package duty_pkg SHALL hold the state enum, DIVIDEND_W = 42, DIVISOR_W = 33, DUTY_W = 16 and the SCALE default.
REQ-028 The divider SHALL be a sub-module div_restoring.
- Parameters: widths.
- Ports: start, dividend, divisor, quotient, done.
- Restoring algorithm, one bit per clock.
REQ-029 duty_meter SHALL hold the gate-edge detection, settle counter, FSM and output registers.

Verification
REQ-030 cnt_high = 250, cnt_low = 750, SETTLE = 2, close at E -> valid at E+46, duty = 250, err = 0.
REQ-031 cnt_high = 1, cnt_low = 2 -> duty = 333 (truncated), err = 0.
REQ-032 cnt_high = 0, cnt_low = 0 -> valid at E+4, duty = 0, err = 1.
REQ-033 cnt_high = 0xFFFF_FFFF, cnt_low = 0xFFFF_FFFF -> duty = 500; confirms no overflow in the 33-bit sum.
REQ-034 Second gate close 10 cycles after E -> ovr pulses once; the first result is unchanged; exactly one valid.
REQ-035 rst pulsed at E+20 -> no valid; busy = 0 at once; the next close gives a correct result.

Source files
------------

// File: rtl/duty_pkg.sv
// Shared types and widths for the duty-cycle meter and its divider.
package duty_pkg;

    localparam int CNT_W        = 32;
    localparam int DIVIDEND_W   = 42;
    localparam int DIVISOR_W    = 33;
    localparam int DUTY_W       = 16;
    localparam int SCALE_DEF    = 1000;
    localparam int SETTLE_CNT_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        LOAD,
        DIV,
        DONE
    } state_t;

endpackage

// File: rtl/duty_meter_if.sv
// Gate/count inputs and result outputs of the duty meter; master drives the gate side.
interface duty_meter_if;
    import duty_pkg::*;

    logic              fgate;
    logic [CNT_W-1:0]  cnt_high;
    logic [CNT_W-1:0]  cnt_low;
    logic [DUTY_W-1:0] duty;
    logic              valid;
    logic              busy;
    logic              err;
    logic              ovr;

    modport master (
        output fgate, cnt_high, cnt_low,
        input  duty, valid, busy, err, ovr
    );

    modport slave (
        input  fgate, cnt_high, cnt_low,
        output duty, valid, busy, err, ovr
    );

endinterface

// File: rtl/div_restoring.sv
// Unsigned restoring divider, one quotient bit per clock, MSB first, truncating.
module div_restoring
    import duty_pkg::*;
#(
    parameter int DIVIDEND_BITS = DIVIDEND_W,
    parameter int DIVISOR_BITS  = DIVISOR_W,
    parameter int QUOT_BITS     = DUTY_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [DIVIDEND_BITS-1:0] dividend,
    input  logic [DIVISOR_BITS-1:0]  divisor,
    output logic [QUOT_BITS-1:0]     quotient,
    output logic                     done
);

    localparam int                CNT_BITS = $clog2(DIVIDEND_BITS);
    localparam logic [CNT_BITS-1:0] LAST   = CNT_BITS'(DIVIDEND_BITS - 1);

    // dq_q starts as the dividend and is shifted left, collecting quotient bits at the bottom
    logic [DIVIDEND_BITS-1:0] dq_q;
    logic [DIVISOR_BITS-1:0]  rem_q;
    logic [DIVISOR_BITS-1:0]  dv_q;
    logic [CNT_BITS-1:0]      cnt_q;
    logic                     run_q;

    logic                     bit_d;
    logic [DIVISOR_BITS-1:0]  rem_d;

    always_comb begin
        bit_d = ({rem_q, dq_q[DIVIDEND_BITS-1]} >= {1'b0, dv_q});
        rem_d = {rem_q[DIVISOR_BITS-2:0], dq_q[DIVIDEND_BITS-1]};
        if (bit_d) begin
            rem_d = DIVISOR_BITS'({rem_q, dq_q[DIVIDEND_BITS-1]} - {1'b0, dv_q});
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dq_q  <= '0;
            rem_q <= '0;
            dv_q  <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (start) begin
            dq_q  <= dividend;
            rem_q <= '0;
            dv_q  <= divisor;
            cnt_q <= '0;
            run_q <= 1'b1;
        end else if (run_q) begin
            dq_q  <= {dq_q[DIVIDEND_BITS-2:0], bit_d};
            rem_q <= rem_d;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST) begin
                run_q <= 1'b0;
            end
        end
    end

    // done marks the cycle whose edge produces the final quotient bit
    assign done     = run_q && (cnt_q == LAST);
    assign quotient = dq_q[QUOT_BITS-1:0];

endmodule

// File: rtl/duty_meter.sv
// Duty-cycle meter: on gate close waits SETTLE clocks, latches the counts and
// divides high*SCALE by (high+low), reporting per-mille duty with a divide-by-zero flag.
module duty_meter
    import duty_pkg::*;
#(
    parameter int SETTLE = 2,
    parameter int SCALE  = SCALE_DEF
) (
    input logic         clk,
    input logic         rst,
    duty_meter_if.slave bus
);

    localparam logic [SETTLE_CNT_W-1:0] SETTLE_LAST = SETTLE_CNT_W'(SETTLE - 1);

    state_t                  state_q;
    logic                    fgate_q;
    logic [SETTLE_CNT_W-1:0] settle_q;
    logic                    zero_q;
    logic [DUTY_W-1:0]       duty_q;
    logic                    valid_q;
    logic                    busy_q;
    logic                    err_q;
    logic                    ovr_q;

    logic                    close_d;
    logic [DIVIDEND_W-1:0]   dividend_d;
    logic [DIVISOR_W-1:0]    divisor_d;
    logic                    div_start_d;
    logic                    div_done_d;
    logic [DUTY_W-1:0]       quot_d;

    assign close_d     = fgate_q & ~bus.fgate;
    assign dividend_d  = DIVIDEND_W'(bus.cnt_high) * DIVIDEND_W'(SCALE);
    // carry kept so two full-scale counts do not wrap
    assign divisor_d   = {1'b0, bus.cnt_high} + {1'b0, bus.cnt_low};
    assign div_start_d = (state_q == LOAD) && (divisor_d != '0);

    div_restoring #(
        .DIVIDEND_BITS (DIVIDEND_W),
        .DIVISOR_BITS  (DIVISOR_W),
        .QUOT_BITS     (DUTY_W)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start_d),
        .dividend (dividend_d),
        .divisor  (divisor_d),
        .quotient (quot_d),
        .done     (div_done_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            fgate_q  <= 1'b0;
            settle_q <= '0;
            zero_q   <= 1'b0;
            duty_q   <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            fgate_q <= bus.fgate;
            valid_q <= 1'b0;
            ovr_q   <= close_d && (state_q != IDLE);
            case (state_q)
                IDLE: begin
                    if (close_d) begin
                        state_q  <= (SETTLE == 0) ? LOAD : WAIT;
                        settle_q <= '0;
                        busy_q   <= 1'b1;
                    end
                end
                WAIT: begin
                    if (settle_q == SETTLE_LAST) begin
                        state_q <= LOAD;
                    end else begin
                        settle_q <= settle_q + 1'b1;
                    end
                end
                LOAD: begin
                    zero_q  <= (divisor_d == '0);
                    state_q <= (divisor_d == '0) ? DONE : DIV;
                end
                DIV: begin
                    if (div_done_d) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    duty_q  <= zero_q ? '0 : quot_d;
                    err_q   <= zero_q;
                    valid_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.duty  = duty_q;
    assign bus.valid = valid_q;
    assign bus.busy  = busy_q;
    assign bus.err   = err_q;
    assign bus.ovr   = ovr_q;

endmodule

// File: tb/tb_duty_meter.sv
// Scoreboard bench for duty_meter: stimulus queues expected results, a monitor checks each valid.
module tb_duty_meter;

    typedef struct {
        int duty;
        int err;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   vld_cnt = 0;
    int   ovr_cnt = 0;
    exp_t sb[$];

    duty_meter_if bus ();

    duty_meter #(.SETTLE(2), .SCALE(1000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // monitor: every valid pops one expectation
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (bus.ovr) ovr_cnt++;
            if (bus.valid) begin
                vld_cnt++;
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_valid: got duty=%0d err=%0d expected no valid", bus.duty, bus.err);
                end else begin
                    e = sb.pop_front();
                    check("duty", longint'(bus.duty), longint'(e.duty));
                    check("err", longint'(bus.err), longint'(e.err));
                    check("valid_cycle", longint'(cyc), longint'(e.cyc));
                end
            end
        end
    end

    // raise the gate for two cycles then drop it; returns the detection edge E
    task automatic do_close(input logic [31:0] hi, input logic [31:0] lo,
                            input int exp_duty, input int exp_err, input int lat,
                            input bit push, output int e_edge);
        exp_t e;
        @(negedge clk);
        bus.cnt_high = hi;
        bus.cnt_low  = lo;
        bus.fgate    = 1'b1;
        repeat (2) @(negedge clk);
        bus.fgate = 1'b0;
        e_edge = cyc + 1;
        if (push) begin
            e.duty = exp_duty;
            e.err  = exp_err;
            e.cyc  = e_edge + lat;
            sb.push_back(e);
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while ((sb.size() != 0 || bus.busy) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) begin
            total++;
            bad++;
            $display("FAIL timeout: got pending=%0d busy=%0d expected idle", sb.size(), bus.busy);
        end
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e_edge;
        int v0;
        int o0;
        bus.fgate    = 1'b0;
        bus.cnt_high = '0;
        bus.cnt_low  = '0;
        repeat (3) @(negedge clk);
        check("rst_duty", longint'(bus.duty), 0);
        check("rst_valid", longint'(bus.valid), 0);
        check("rst_busy", longint'(bus.busy), 0);
        check("rst_err", longint'(bus.err), 0);
        check("rst_ovr", longint'(bus.ovr), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        do_close(32'd250, 32'd750, 250, 0, 46, 1'b1, e_edge);
        @(negedge clk);
        check("busy_after_close", longint'(bus.busy), 1);
        wait_done();
        check("busy_idle", longint'(bus.busy), 0);

        do_close(32'd1, 32'd2, 333, 0, 46, 1'b1, e_edge);
        wait_done();

        do_close(32'd0, 32'd0, 0, 1, 4, 1'b1, e_edge);
        wait_done();
        check("err_held", longint'(bus.err), 1);

        do_close(32'hFFFF_FFFF, 32'hFFFF_FFFF, 500, 0, 46, 1'b1, e_edge);
        wait_done();

        do_close(32'd7, 32'd0, 1000, 0, 46, 1'b1, e_edge);
        wait_done();

        do_close(32'd3, 32'd1, 750, 0, 46, 1'b1, e_edge);
        wait_done();

        // second close at E+10 while dividing; counts also change after LOAD
        v0 = vld_cnt;
        o0 = ovr_cnt;
        do_close(32'd250, 32'd750, 250, 0, 46, 1'b1, e_edge);
        while (cyc < e_edge + 7) @(negedge clk);
        bus.fgate = 1'b1;
        while (cyc < e_edge + 9) @(negedge clk);
        bus.fgate    = 1'b0;
        bus.cnt_high = 32'd5;
        bus.cnt_low  = 32'd9;
        wait_done();
        repeat (5) @(negedge clk);
        check("ovr_pulses", longint'(ovr_cnt - o0), 1);
        check("valid_count_ovr", longint'(vld_cnt - v0), 1);

        // reset in the middle of a computation
        v0 = vld_cnt;
        do_close(32'd1, 32'd2, 0, 0, 46, 1'b0, e_edge);
        while (cyc < e_edge + 19) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mid_busy", longint'(bus.busy), 0);
        check("rst_mid_duty", longint'(bus.duty), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        check("valid_count_rst", longint'(vld_cnt - v0), 0);
        check("low_gate_no_trigger", longint'(bus.busy), 0);

        do_close(32'd1, 32'd2, 333, 0, 46, 1'b1, e_edge);
        wait_done();
        check("scoreboard_empty", longint'(sb.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
